// File: rtl/store_merge_unit_if.sv
// -----------------------------------------------------------------------------
// store_merge_unit_if
//
// Bundles the MEM-stage request handshake and the data-memory bus used by
// store_merge_unit. The store unit is the bus master: it accepts store requests
// from the pipeline and issues read/write strobes to the data memory.
//
// Modports:
//   master - the store merge unit itself.
//            in : store_req, store_type, addr, wdata,
//                 mem_rdata, mem_rd_valid, mem_wr_ack
//            out: stall, done, err,
//                 mem_addr, mem_rd_en, mem_wr_en, mem_wdata
//   slave  - the environment (pipeline MEM stage plus data memory), which
//            sees the same signals with the directions reversed.
//
// Signals:
//   store_req    1-cycle store request, sampled only while the unit is idle
//   store_type   00 = SB, 01 = SH, 10 = SW, 11 = illegal
//   addr         byte address of the store
//   wdata        rt register value (low 8/16/32 bits used)
//   stall        pipeline hold
//   done         1-cycle pulse when a store completes
//   err          1-cycle pulse on misalignment, illegal type or timeout
//   mem_addr     word-aligned memory address (low two bits always 0)
//   mem_rd_en    read strobe, held until mem_rd_valid
//   mem_rdata    read data, meaningful only with mem_rd_valid
//   mem_rd_valid read data valid
//   mem_wr_en    write strobe, held until mem_wr_ack
//   mem_wdata    merged word to write
//   mem_wr_ack   write accepted
// -----------------------------------------------------------------------------
interface store_merge_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    // Pipeline side
    logic                  store_req;
    logic [1:0]            store_type;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  stall;
    logic                  done;
    logic                  err;

    // Data memory side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [31:0]           mem_rdata;
    logic                  mem_rd_valid;
    logic                  mem_wr_en;
    logic [31:0]           mem_wdata;
    logic                  mem_wr_ack;

    modport master (
        input  store_req,
        input  store_type,
        input  addr,
        input  wdata,
        output stall,
        output done,
        output err,
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        input  mem_rd_valid,
        output mem_wr_en,
        output mem_wdata,
        input  mem_wr_ack
    );

    modport slave (
        output store_req,
        output store_type,
        output addr,
        output wdata,
        input  stall,
        input  done,
        input  err,
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        output mem_rd_valid,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_wr_ack
    );
endinterface

// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// MEM-stage store path. Narrows the rt register value to the store width
// (SB/SH/SW) and places it in the addressed little-endian byte lane. The data
// memory has no byte enables, so sub-word stores do a read-modify-write: read
// the containing word, merge the new lane in, write the word back. Word stores
// go straight to the write phase. The pipeline is held with stall until the
// write is acknowledged.
//
// Parameters:
//   ADDR_WIDTH  byte-address width of addr / mem_addr
//   TIMEOUT     cycles to wait for mem_rd_valid / mem_wr_ack before aborting
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      store_merge_unit_if.master (request handshake + memory bus)
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    store_merge_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    // The counter only has to reach TIMEOUT-1.
    localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_type;
    logic [1:0]            r_lane;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_rd_en;
    logic                  r_mem_wr_en;
    logic [31:0]           r_mem_wdata;
    logic                  r_stall;
    logic                  r_done;
    logic                  r_err;

    logic                  w_legal;
    logic                  w_accept;

    // Alignment / type check: SB is always aligned, SH needs an even address,
    // SW needs a word-aligned address, type 11 is never legal.
    function automatic logic f_legal(input logic [1:0] t, input logic [1:0] lane);
        logic ok;
        case (t)
            ST_SB:   ok = 1'b1;
            ST_SH:   ok = ~lane[0];
            ST_SW:   ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replace the addressed lane of the word read from memory with the low
    // bits of the register value; untouched lanes keep the memory contents.
    function automatic logic [31:0] f_merge(input logic [1:0]  t,
                                            input logic [1:0]  lane,
                                            input logic [31:0] old_word,
                                            input logic [31:0] wd);
        logic [31:0] w;
        w = old_word;
        case (t)
            ST_SB:   w[{lane, 3'b000} +: 8]        = wd[7:0];
            ST_SH:   w[{lane[1], 4'b0000} +: 16]   = wd[15:0];
            default: w                             = wd;
        endcase
        return w;
    endfunction

    assign w_legal  = f_legal(bus.store_type, bus.addr[1:0]);
    assign w_accept = (r_state == S_IDLE) && bus.store_req && w_legal;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_type      <= '0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= '0;
            r_stall     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // done and err are single-cycle pulses by default.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.store_req) begin
                        if (w_legal) begin
                            r_type     <= bus.store_type;
                            r_lane     <= bus.addr[1:0];
                            r_wdata    <= bus.wdata;
                            r_mem_addr <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                            r_stall    <= 1'b1;
                            r_cnt      <= '0;
                            if (bus.store_type == ST_SW) begin
                                // Full word: nothing to merge, skip the read.
                                r_mem_wdata <= bus.wdata;
                                r_mem_wr_en <= 1'b1;
                                r_state     <= S_WRITE;
                            end else begin
                                r_mem_rd_en <= 1'b1;
                                r_state     <= S_READ;
                            end
                        end else begin
                            // Rejected request: report it and stay idle
                            // without touching memory.
                            r_err <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    // A valid arriving in the last allowed cycle still wins.
                    if (bus.mem_rd_valid) begin
                        r_mem_wdata <= f_merge(r_type, r_lane, bus.mem_rdata, r_wdata);
                        r_mem_rd_en <= 1'b0;
                        r_mem_wr_en <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_WRITE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_rd_en <= 1'b0;
                        r_stall     <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    // An ack arriving in the last allowed cycle still wins.
                    if (bus.mem_wr_ack) begin
                        r_mem_wr_en <= 1'b0;
                        r_stall     <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_wr_en <= 1'b0;
                        r_stall     <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    // Requests arriving in this cycle are ignored; the next
                    // one is taken once we are back in IDLE.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // stall must rise in the same cycle the request is accepted, so the
    // registered hold is OR-ed with the combinational acceptance.
    assign bus.stall     = r_stall | w_accept;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_merge_unit.sv
// -----------------------------------------------------------------------------
// tb_store_merge_unit
//
// Bench for store_merge_unit with TIMEOUT = 4. The bench plays the role of the
// pipeline and of a data memory with programmable read/write latency. Expected
// results come from a vector table with hand-computed values, a few hand-driven
// multi-cycle sequences, and a transaction-level reference model for random
// stores.
// -----------------------------------------------------------------------------
module tb_store_merge_unit;

    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    store_merge_unit_if #(.ADDR_WIDTH(AW)) bus ();

    store_merge_unit #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Sparse word-addressed memory image.
    logic [31:0] mem [logic [31:0]];

    // Observations of the last run_store call.
    int   ob_done, ob_err, ob_rd, ob_wr, ob_stall, ob_writes;
    logic ob_stall0, ob_addr_bad;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] init;
        int          rl;
        int          wl;
        logic [31:0] e_word;
        int          e_done;
        int          e_err;
        int          e_rd;
        int          e_wr;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Reference: a store of 2^t bytes is legal when the address is a multiple
    // of its size; the new bytes land at byte offset addr%4.
    function automatic bit ref_legal(input logic [1:0] t, input logic [31:0] a);
        if (t == 2'd3) return 1'b0;
        return (int'(a[1:0]) % (1 << t)) == 0;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [1:0] t, input logic [31:0] a,
                                              input logic [31:0] old_w, input logic [31:0] wd);
        int          nbytes;
        int          sh;
        logic [63:0] mask;
        logic [63:0] ins;
        nbytes = 1 << t;
        sh     = 8 * int'(a[1:0]);
        mask   = ((64'd1 << (8 * nbytes)) - 64'd1) << sh;
        ins    = ({32'd0, wd} << sh) & mask;
        return (old_w & ~mask[31:0]) | ins[31:0];
    endfunction

    // Issue one store request and act as memory until done/err or a 40-cycle
    // bound. Cycle n counts negedges after the request cycle (n = 0).
    task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                             input int rd_lat, input int wr_lat);
        int          rcnt;
        int          wcnt;
        logic [31:0] word;
        word = {a[31:2], 2'b00};
        rcnt = 0; wcnt = 0;
        ob_done = -1; ob_err = -1; ob_rd = 0; ob_wr = 0; ob_stall = 0; ob_writes = 0;
        ob_addr_bad = 1'b0;
        @(negedge clk);
        bus.store_req  = 1'b1;
        bus.store_type = t;
        bus.addr       = a;
        bus.wdata      = wd;
        #1 ob_stall0 = bus.stall;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.stall) ob_stall++;
            if (bus.done)  ob_done = n;
            if (bus.err)   ob_err  = n;
            // Request inputs scrambled after acceptance must not matter.
            bus.store_req    = 1'b0;
            bus.store_type   = 2'($urandom);
            bus.addr         = $urandom;
            bus.wdata        = $urandom;
            bus.mem_rd_valid = 1'b0;
            bus.mem_wr_ack   = 1'b0;
            bus.mem_rdata    = $urandom;
            if ((bus.mem_rd_en || bus.mem_wr_en) && bus.mem_addr != word) ob_addr_bad = 1'b1;
            if (bus.mem_rd_en) begin
                ob_rd++;
                if (rcnt == rd_lat) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rdata    = mem_word(bus.mem_addr);
                end
                rcnt++;
            end
            if (bus.mem_wr_en) begin
                ob_wr++;
                if (wcnt == wr_lat) begin
                    bus.mem_wr_ack     = 1'b1;
                    mem[bus.mem_addr]  = bus.mem_wdata;
                    ob_writes++;
                end
                wcnt++;
            end
            if (ob_done >= 0 || ob_err >= 0) break;
        end
    endtask

    // Random store checked against the reference model.
    task automatic model_txn(input string tag, input logic [1:0] t, input logic [31:0] a,
                             input logic [31:0] wd, input int rd_lat, input int wr_lat);
        logic [31:0] word;
        logic [31:0] old_w;
        bit          legal, rd_to, wr_to, ok;
        int          e_rd, e_wr, e_end;
        word  = {a[31:2], 2'b00};
        old_w = mem_word(word);
        legal = ref_legal(t, a);
        rd_to = legal && (t != 2'd2) && (rd_lat >= TO);
        wr_to = legal && !rd_to && (wr_lat >= TO);
        ok    = legal && !rd_to && !wr_to;
        e_rd  = (!legal || t == 2'd2) ? 0 : (rd_to ? TO : rd_lat + 1);
        e_wr  = (!legal || rd_to) ? 0 : (wr_to ? TO : wr_lat + 1);
        e_end = legal ? (e_rd + e_wr + 1) : 1;
        run_store(t, a, wd, rd_lat, wr_lat);
        chk({tag, ".stall_req"}, ob_stall0, legal);
        chk({tag, ".done_cyc"},  ob_done,   ok ? e_end : -1);
        chk({tag, ".err_cyc"},   ob_err,    ok ? -1 : e_end);
        chk({tag, ".rd_cycles"}, ob_rd,     e_rd);
        chk({tag, ".wr_cycles"}, ob_wr,     e_wr);
        chk({tag, ".stall_cyc"}, ob_stall,  e_rd + e_wr);
        chk({tag, ".writes"},    ob_writes, ok ? 1 : 0);
        chk({tag, ".addr_bad"},  ob_addr_bad, 0);
        chk({tag, ".word"},      mem[word], ok ? ref_merge(t, a, old_w, wd) : old_w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] rt;
        int         r;

        bus.store_req    = 1'b0;
        bus.store_type   = 2'b00;
        bus.addr         = '0;
        bus.wdata        = '0;
        bus.mem_rdata    = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_wr_ack   = 1'b0;
        reset_n          = 1'b0;

        //          t      addr    wdata         init          rl  wl  e_word        done err rd wr
        vt[0]  = '{2'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 0,  0,  32'hDEADBEEF,  2, -1, 0, 1};
        vt[1]  = '{2'd0, 32'h23, 32'h123456A5, 32'h11223344, 0,  0,  32'hA5223344,  3, -1, 1, 1};
        vt[2]  = '{2'd1, 32'h06, 32'hFFFFBEEF, 32'h00000000, 3,  0,  32'hBEEF0000,  6, -1, 4, 1};
        vt[3]  = '{2'd1, 32'h05, 32'h0000BEEF, 32'h55555555, 0,  0,  32'h55555555, -1,  1, 0, 0};
        vt[4]  = '{2'd2, 32'h02, 32'hDEADBEEF, 32'h66666666, 0,  0,  32'h66666666, -1,  1, 0, 0};
        vt[5]  = '{2'd3, 32'h08, 32'h12345678, 32'h77777777, 0,  0,  32'h77777777, -1,  1, 0, 0};
        vt[6]  = '{2'd2, 32'h30, 32'hCAFEF00D, 32'h89ABCDEF, 0, 99,  32'h89ABCDEF, -1,  5, 0, 4};
        vt[7]  = '{2'd2, 32'h30, 32'h0BADC0DE, 32'h89ABCDEF, 0,  0,  32'h0BADC0DE,  2, -1, 0, 1};
        vt[8]  = '{2'd0, 32'h40, 32'h000000FF, 32'hAABBCCDD, 1,  2,  32'hAABBCCFF,  6, -1, 2, 3};
        vt[9]  = '{2'd1, 32'h42, 32'h00001234, 32'hAABBCCDD, 0,  0,  32'h1234CCDD,  3, -1, 1, 1};
        vt[10] = '{2'd0, 32'h51, 32'h00000099, 32'h01020304, 99, 0,  32'h01020304, -1,  5, 4, 0};
        vt[11] = '{2'd2, 32'h20, 32'h13579BDF, 32'h00000000, 0,  3,  32'h13579BDF,  5, -1, 0, 4};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.ctrl", {bus.stall, bus.done, bus.err, bus.mem_rd_en, bus.mem_wr_en}, 0);
        chk("reset.mem_addr",  bus.mem_addr,  0);
        chk("reset.mem_wdata", bus.mem_wdata, 0);
        reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            mem[{vt[i].a[31:2], 2'b00}] = vt[i].init;
            run_store(vt[i].t, vt[i].a, vt[i].wd, vt[i].rl, vt[i].wl);
            chk($sformatf("vec%0d.done_cyc", i),  ob_done,  vt[i].e_done);
            chk($sformatf("vec%0d.err_cyc", i),   ob_err,   vt[i].e_err);
            chk($sformatf("vec%0d.rd_cycles", i), ob_rd,    vt[i].e_rd);
            chk($sformatf("vec%0d.wr_cycles", i), ob_wr,    vt[i].e_wr);
            chk($sformatf("vec%0d.word", i),      mem[{vt[i].a[31:2], 2'b00}], vt[i].e_word);
        end

        // Asynchronous reset in the middle of an SB read
        mem[32'h60] = 32'h0F0E0D0C;
        @(negedge clk);
        bus.store_req = 1'b1; bus.store_type = 2'd0; bus.addr = 32'h61; bus.wdata = 32'h000000AB;
        @(negedge clk);
        bus.store_req = 1'b0;
        chk("rstmid.rd_en_before", bus.mem_rd_en, 1);
        chk("rstmid.stall_before", bus.stall, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.rd_en_after", bus.mem_rd_en, 0);
        chk("rstmid.stall_after", bus.stall, 0);
        chk("rstmid.mem_addr",    bus.mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rstmid.no_write", mem[32'h60], 32'h0F0E0D0C);
        model_txn("rstmid.fresh", 2'd0, 32'h62, 32'h000000AB, 0, 0);

        // store_req while in WRITE is ignored and not re-latched
        mem[32'h70] = 32'h0;
        @(negedge clk);
        bus.store_req = 1'b1; bus.store_type = 2'd2; bus.addr = 32'h70; bus.wdata = 32'h11111111;
        @(negedge clk);
        bus.store_req = 1'b1; bus.store_type = 2'd0; bus.addr = 32'h81; bus.wdata = 32'h22222222;
        chk("busy.wr_en1", bus.mem_wr_en, 1);
        @(negedge clk);
        bus.store_req = 1'b0;
        chk("busy.wr_en2",     bus.mem_wr_en, 1);
        chk("busy.mem_wdata",  bus.mem_wdata, 32'h11111111);
        chk("busy.mem_addr",   bus.mem_addr,  32'h70);
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        bus.mem_wr_ack = 1'b0;
        chk("busy.done",  bus.done, 1);
        chk("busy.stall", bus.stall, 0);
        @(negedge clk);
        chk("busy.after", {bus.mem_rd_en, bus.mem_wr_en, bus.stall, bus.done, bus.err}, 0);

        // Random stores against the reference model
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 9);
            rt = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            model_txn($sformatf("rnd%0d", k), rt, 32'($urandom_range(0, 63)), $urandom,
                      $urandom_range(0, 5), $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- MEM-stage store path of the MIPS datapath: the narrowing counterpart of the load-side sign extension.
- Takes a 32-bit register value plus a store width (SB/SH/SW), truncates it and places it in the correct byte lane.
- Data memory has no byte enables, so SB/SH use read-modify-write: read the word, merge the lane, write it back.
- Holds the pipeline with `stall` until the write is acknowledged.

Parameters:
- ADDR_WIDTH, 32, byte-address width of `addr` and `mem_addr`.
- TIMEOUT, 16, maximum cycles to wait for `mem_rd_valid` or `mem_wr_ack` before aborting with an error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- store_req  input  1  one-cycle request from the MEM stage; sampled only in IDLE.
- store_type  input  2  00 = SB, 01 = SH, 10 = SW, 11 = illegal.
- addr  input  ADDR_WIDTH  byte address of the store.
- wdata  input  32  rt register value; low 8/16/32 bits are used.
- mem_addr  output  ADDR_WIDTH  word-aligned address; low 2 bits are always 0.
- mem_rd_en  output  1  read strobe; held until `mem_rd_valid`.
- mem_rdata  input  32  read data; valid only when `mem_rd_valid` is high.
- mem_rd_valid  input  1  read data valid.
- mem_wr_en  output  1  write strobe; held until `mem_wr_ack`.
- mem_wdata  output  32  merged write word.
- mem_wr_ack  input  1  write accepted.
- stall  output  1  pipeline hold.
- done  output  1  one-cycle pulse when the store completes.
- err  output  1  one-cycle pulse on misaligned, illegal-type or timeout.

Behaviour:
- Reset (async, reset_n = 0):
  - State goes to IDLE immediately, without waiting for a clock edge.
  - All outputs are 0: stall, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata.
  - The timeout counter and all latched request registers are cleared.
  - A reset mid-operation drops the memory strobes at once; no partial write is completed.
- Lane placement (little-endian, lane = addr[1:0]):
  - SB: byte lane k = wdata[7:0], where k = addr[1:0].
  - SH: half lane addr[1] = wdata[15:0].
  - SW: the whole word is wdata.
  - Unselected lanes keep the value of `mem_rdata` captured in READ.
- Alignment check, evaluated in IDLE when store_req = 1:
  - Error cases: SH with addr[0] = 1, SW with addr[1:0] != 0, or store_type = 11.
  - Response: err = 1 for one cycle, the next cycle. No memory access. stall stays 0. Stays in IDLE.
- States:
  - IDLE:
    - On a legal store_req, latch addr, store_type and wdata; assert stall combinationally in that same cycle.
    - SW goes to WRITE with mem_wdata = wdata.
    - SB/SH go to READ.
  - READ:
    - mem_rd_en = 1, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
    - On mem_rd_valid: capture the merged word into mem_wdata and go to WRITE. mem_rd_en drops in the next cycle.
  - WRITE:
    - mem_wr_en = 1, mem_wdata stable.
    - On mem_wr_ack go to DONE.
  - DONE:
    - done = 1 and stall = 0 for one cycle, then IDLE.
    - A new store_req can be accepted the cycle after DONE.
- stall is 1 in READ and WRITE, and in the IDLE cycle of a legal request. It is 0 otherwise.
- Latency (zero-wait memory, i.e. valid/ack in the first strobe cycle):
  - SW: request cycle → WRITE 1 cycle → DONE. done appears 2 cycles after store_req.
  - SB/SH: READ 1 + WRITE 1 → done appears 3 cycles after store_req.
- Timeout:
  - Counter clears on entry to READ/WRITE and increments each cycle without valid/ack.
  - When the counter reaches TIMEOUT-1: pulse err, drop the strobes, go to IDLE. done is not pulsed.
- Boundary cases:
  - store_req while not in IDLE is ignored; the request inputs are not re-latched.
  - mem_wr_ack and mem_rd_valid outside their states are ignored.
  - mem_rd_valid and a timeout in the same cycle: valid wins.
  - mem_wr_ack and a timeout in the same cycle: ack wins.
  - wdata changes after acceptance have no effect, because the value is latched.

Test Plan:
- SW, addr = 0x0000_0010, wdata = 0xDEADBEEF, ack on first cycle → one write of 0xDEADBEEF to 0x10, no read, done exactly 2 cycles after req, stall high for 2 cycles.
- SB, addr = 0x0000_0023, wdata = 0x1234_56A5, mem_rdata = 0x1122_3344 → read 0x20, write 0xA522_3344 to 0x20, done 3 cycles after req.
- SH, addr = 0x0000_0006, wdata = 0xFFFF_BEEF, mem_rdata = 0x0000_0000, rd_valid delayed 3 cycles → write 0x0000_0000 with lane 1 replaced, i.e. 0xBEEF_0000; stall held throughout.
- Misaligned SH at 0x5, SW at 0x2, and store_type = 11 → err pulse each, mem_rd_en and mem_wr_en never asserted, stall 0.
- TIMEOUT = 4, SW with ack never asserted → mem_wr_en high exactly 4 cycles, err pulse, done never pulses, back to IDLE; the next SW completes normally.
- reset_n low during READ of an SB → mem_rd_en and stall drop with no clock edge; after release a fresh SB completes with the correct merge; store_req during WRITE is ignored.
